// File: rtl/seg_pkg.sv
// Shared display types and constants for the seven-segment blocks.
// Segment order {a,b,c,d,e,f,g,dp}, all active-low.
package seg_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      SHOW  = 2'd2
   } state_t;

   localparam logic [7:0] SEG_OFF = 8'hFF;

   // {a,b,c,d,e,f,g} per hex value, MSB = a
   localparam logic [6:0] HEX_SEG [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Datapath-facing and pin-facing signals of the scan controller.
// master drives data/masks/strobes, slave (the controller) drives the pins.
interface seg_scan_ctrl_if #(
   parameter int NUM_DIGITS = 8
);
   logic                    en;
   logic                    load;
   logic [4*NUM_DIGITS-1:0] data_in;
   logic [NUM_DIGITS-1:0]   dp_in;
   logic [NUM_DIGITS-1:0]   blank_in;
   logic [NUM_DIGITS-1:0]   an;
   logic [7:0]              seg;
   logic                    frame_done;

   modport master (
      output en, load, data_in, dp_in, blank_in,
      input  an, seg, frame_done
   );

   modport slave (
      input  en, load, data_in, dp_in, blank_in,
      output an, seg, frame_done
   );
endinterface

// File: rtl/seg_hex_decode.sv
// Hex nibble plus decimal point to active-low {a..g,dp} segment pattern.
// Purely combinational, no backpressure.
module seg_hex_decode
   import seg_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       dp,
   output logic [7:0] seg
);

   assign seg = {HEX_SEG[nibble], ~dp};

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scanner with dead-time guard and frame-synchronous data swap.
// New data shows from the next frame start; outputs depend only on registered state; no backpressure.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS   = 8,
   parameter int DIGIT_CYCLES = 100000,
   parameter int BLANK_CYCLES = 1000
)(
   input  logic         clk,
   input  logic         rst,
   seg_scan_ctrl_if.slave bus
);

   localparam int CNT_MAX  = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
   localparam int CNT_SPAN = (CNT_MAX < 2) ? 2 : CNT_MAX;
   localparam int CW       = $clog2(CNT_SPAN);
   localparam int IW       = $clog2(NUM_DIGITS);

   localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGIT_CYCLES - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
   // With no guard time the scan never leaves SHOW once started
   localparam state_t        LIT_NEXT   = (BLANK_CYCLES == 0) ? SHOW : BLANK;
   localparam state_t        START_NEXT = (BLANK_CYCLES == 0) ? SHOW : BLANK;

   state_t                  state, state_nxt;
   logic [CW-1:0]           cnt, cnt_nxt;
   logic [IW-1:0]           idx, idx_nxt;
   logic                    frame_done_q, frame_done_nxt;
   logic                    frame_start;

   logic [4*NUM_DIGITS-1:0] act_data, pend_data;
   logic [NUM_DIGITS-1:0]   act_dp, pend_dp;
   logic [NUM_DIGITS-1:0]   act_blank, pend_blank;
   logic                    pend_valid;

   logic [NUM_DIGITS-1:0]   an_d;
   logic [7:0]              seg_d;
   logic [7:0]              dec_seg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         idx          <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         idx          <= idx_nxt;
         frame_done_q <= frame_done_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      idx_nxt        = idx;
      frame_done_nxt = 1'b0;
      frame_start    = 1'b0;
      if (!bus.en) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
         idx_nxt   = '0;
      end else begin
         unique case (state)
            IDLE: begin
               state_nxt   = START_NEXT;
               cnt_nxt     = '0;
               idx_nxt     = '0;
               frame_start = 1'b1;
            end
            BLANK: begin
               if (cnt == BLANK_LAST) begin
                  state_nxt = SHOW;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + CW'(1);
               end
            end
            SHOW: begin
               if (cnt == DIGIT_LAST) begin
                  state_nxt = LIT_NEXT;
                  cnt_nxt   = '0;
                  if (idx == IDX_LAST) begin
                     idx_nxt        = '0;
                     frame_done_nxt = 1'b1;
                     frame_start    = 1'b1;
                  end else begin
                     idx_nxt = idx + IW'(1);
                  end
               end else begin
                  cnt_nxt = cnt + CW'(1);
               end
            end
            default: begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
               idx_nxt   = '0;
            end
         endcase
      end
   end

   // A load landing on a frame start bypasses pending so it is shown this frame
   always_ff @(posedge clk) begin
      if (rst) begin
         act_data   <= '0;
         act_dp     <= '0;
         act_blank  <= '0;
         pend_data  <= '0;
         pend_dp    <= '0;
         pend_blank <= '0;
         pend_valid <= 1'b0;
      end else if (frame_start) begin
         if (bus.load) begin
            act_data  <= bus.data_in;
            act_dp    <= bus.dp_in;
            act_blank <= bus.blank_in;
         end else if (pend_valid) begin
            act_data  <= pend_data;
            act_dp    <= pend_dp;
            act_blank <= pend_blank;
         end
         pend_valid <= 1'b0;
      end else if (bus.load) begin
         pend_data  <= bus.data_in;
         pend_dp    <= bus.dp_in;
         pend_blank <= bus.blank_in;
         pend_valid <= 1'b1;
      end
   end

   seg_hex_decode u_dec (
      .nibble (act_data[{idx, 2'b00} +: 4]),
      .dp     (act_dp[idx]),
      .seg    (dec_seg)
   );

   always_comb begin
      an_d  = '1;
      seg_d = SEG_OFF;
      if (state == SHOW) begin
         an_d[idx] = 1'b0;
         if (!act_blank[idx]) begin
            seg_d = dec_seg;
         end
      end
   end

   assign bus.an         = an_d;
   assign bus.seg        = seg_d;
   assign bus.frame_done = frame_done_q;

endmodule
